// File: rtl/vga_cursor_ctrl.sv
// vga_cursor_ctrl: text-mode VGA cursor controller.
// Host writes land in a shadow register set. The active set is loaded from the
// shadow on a vertical-sync rising edge, so the cursor never changes mid-frame.
// A frame-counted blink FSM drives the phase output, and a registered per-pixel
// hit strobe goes to the character renderer.
// Optional build macro: VGA_CUR_RDBACK_EN enables readback of the active
// registers on o_rdata. When it is undefined, o_rdata reads as zero.
module vga_cursor_ctrl #(
  parameter int COL_W = 7,
  parameter int ROW_W = 5,
  parameter int LINE_W = 4,
  parameter logic [7:0] DEF_RATE = 8'd30
) (
  input  logic              i_clk,
  input  logic              i_rst_h,
  input  logic              i_wr_h,
  input  logic              i_rd_h,
  input  logic [2:0]        i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_rdata,
  output logic              o_pend_h,
  input  logic              i_vs_h,
  input  logic              i_de_h,
  input  logic [COL_W-1:0]  i_col,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [LINE_W-1:0] i_line,
  output logic              o_cur_h,
  output logic              o_phase_h
);

  typedef enum logic {COUNT, VS_HIGH} blink_state_t;

  logic [COL_W-1:0] sh_col, act_col;
  logic [ROW_W-1:0] sh_row, act_row;
  logic [7:0]       sh_start, act_start;
  logic [7:0]       sh_end, act_end;
  logic             sh_en, act_en;
  logic             sh_blink, act_blink;
  logic [7:0]       sh_rate, act_rate;
  logic             pend;
  logic             vs_prev;
  logic             vs_rise;
  logic             wr_valid;
  logic             blink_off;
  blink_state_t     state;
  logic [7:0]       frame_cnt;
  logic             phase;

  assign vs_rise   = i_vs_h && !vs_prev;
  assign wr_valid  = i_wr_h && (i_addr <= 3'd5);
  assign blink_off = !act_blink || (act_rate == 8'd0);
  assign o_pend_h  = pend;
  assign o_phase_h = phase;

  // Remember the previous vsync sample. Reset clears it, so a sync pulse that is already high when reset releases counts as a rising edge.
  always_ff @(posedge i_clk) begin
    if (i_rst_h) vs_prev <= 1'b0;
    else         vs_prev <= i_vs_h;
  end

  // Shadow and active register sets. The commit copies the pre-write shadow, and a write in the same cycle re-arms pending.
  always_ff @(posedge i_clk) begin
    if (i_rst_h) begin
      sh_col    <= '0;
      sh_row    <= '0;
      sh_start  <= 8'd14;
      sh_end    <= 8'd15;
      sh_en     <= 1'b1;
      sh_blink  <= 1'b1;
      sh_rate   <= DEF_RATE;
      act_col   <= '0;
      act_row   <= '0;
      act_start <= 8'd14;
      act_end   <= 8'd15;
      act_en    <= 1'b1;
      act_blink <= 1'b1;
      act_rate  <= DEF_RATE;
      pend      <= 1'b0;
    end else begin
      if (vs_rise && pend) begin
        act_col   <= sh_col;
        act_row   <= sh_row;
        act_start <= sh_start;
        act_end   <= sh_end;
        act_en    <= sh_en;
        act_blink <= sh_blink;
        act_rate  <= sh_rate;
        pend      <= 1'b0;
      end
      if (wr_valid) begin
        pend <= 1'b1;
        case (i_addr)
          3'd0:    sh_col   <= i_data[COL_W-1:0];
          3'd1:    sh_row   <= i_data[ROW_W-1:0];
          3'd2:    sh_start <= i_data;
          3'd3:    sh_end   <= i_data;
          3'd4: begin
            sh_en    <= i_data[0];
            sh_blink <= i_data[1];
          end
          default: sh_rate  <= i_data;
        endcase
      end
    end
  end

  // Blink FSM. Count frames on each vsync rise and toggle the phase on the vsync fall once the count reaches the active rate.
  always_ff @(posedge i_clk) begin
    if (i_rst_h) begin
      state     <= COUNT;
      frame_cnt <= 8'd0;
      phase     <= 1'b1;
    end else begin
      case (state)
        COUNT: begin
          if (vs_rise) begin
            state     <= VS_HIGH;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        VS_HIGH: begin
          if (!i_vs_h) begin
            state <= COUNT;
            if (frame_cnt >= act_rate) begin
              phase     <= ~phase;
              frame_cnt <= 8'd0;
            end
          end
        end
        default: state <= COUNT;
      endcase
      if (blink_off) begin
        frame_cnt <= 8'd0;
        phase     <= 1'b1;
      end
    end
  end

  // Per-pixel cursor hit, registered, so it lags the pixel coordinates by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst_h) o_cur_h <= 1'b0;
    else o_cur_h <= i_de_h && act_en && phase &&
                    (i_col == act_col) && (i_row == act_row) &&
                    (i_line >= act_start[LINE_W-1:0]) &&
                    (i_line <= act_end[LINE_W-1:0]);
  end

`ifdef VGA_CUR_RDBACK_EN
  // Readback of the active set. The value is loaded on a read strobe and held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst_h) o_rdata <= 8'd0;
    else if (i_rd_h) begin
      case (i_addr)
        3'd0:    o_rdata <= 8'(act_col);
        3'd1:    o_rdata <= 8'(act_row);
        3'd2:    o_rdata <= act_start;
        3'd3:    o_rdata <= act_end;
        3'd4:    o_rdata <= {6'd0, act_blink, act_en};
        3'd5:    o_rdata <= act_rate;
        default: o_rdata <= 8'd0;
      endcase
    end
  end
`else
  logic unused_bits;

  // Readback is absent in this build. The read strobe and the unused upper line bits are collected here on purpose.
  always_comb begin
    unused_bits = i_rd_h ^ (^act_start[7:LINE_W]) ^ (^act_end[7:LINE_W]);
  end

  assign o_rdata = 8'd0;
`endif

endmodule

// File: tb/tb_vga_cursor_ctrl.sv
// tb_vga_cursor_ctrl: self-checking bench for vga_cursor_ctrl.
// A small reference model of the shadow/active registers and the blink FSM
// pushes expected values to a scoreboard queue when stimulus is driven. Each
// scenario task then pops those values and compares them with the DUT outputs.
module tb_vga_cursor_ctrl;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;
  localparam int LINE_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_h = 1'b0;
  logic              i_wr_h = 1'b0;
  logic              i_rd_h = 1'b0;
  logic [2:0]        i_addr = '0;
  logic [7:0]        i_data = '0;
  logic [7:0]        o_rdata;
  logic              o_pend_h;
  logic              i_vs_h = 1'b0;
  logic              i_de_h = 1'b0;
  logic [COL_W-1:0]  i_col = '0;
  logic [ROW_W-1:0]  i_row = '0;
  logic [LINE_W-1:0] i_line = '0;
  logic              o_cur_h;
  logic              o_phase_h;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  logic [7:0] m_sh[6];
  logic [7:0] m_act[6];
  bit m_pend;
  int m_cnt;
  bit m_phase;

  vga_cursor_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W), .LINE_W(LINE_W), .DEF_RATE(8'd30)) dut (
    .i_clk(i_clk), .i_rst_h(i_rst_h), .i_wr_h(i_wr_h), .i_rd_h(i_rd_h),
    .i_addr(i_addr), .i_data(i_data), .o_rdata(o_rdata), .o_pend_h(o_pend_h),
    .i_vs_h(i_vs_h), .i_de_h(i_de_h), .i_col(i_col), .i_row(i_row),
    .i_line(i_line), .o_cur_h(o_cur_h), .o_phase_h(o_phase_h)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void m_reset();
    m_sh[0] = 8'd0; m_sh[1] = 8'd0; m_sh[2] = 8'd14;
    m_sh[3] = 8'd15; m_sh[4] = 8'd3; m_sh[5] = 8'd30;
    for (int k = 0; k < 6; k++) m_act[k] = m_sh[k];
    m_pend = 0;
    m_cnt = 0;
    m_phase = 1;
  endfunction

  function automatic bit m_disabled();
    return (m_act[4][1] == 1'b0) || (m_act[5] == 8'd0);
  endfunction

  function automatic void m_write(int a, logic [7:0] d);
    if (a < 6) begin
      case (a)
        0: m_sh[a] = d & 8'h7f;
        1: m_sh[a] = d & 8'h1f;
        4: m_sh[a] = d & 8'h03;
        default: m_sh[a] = d;
      endcase
      m_pend = 1;
    end
  endfunction

  function automatic void m_rise(bit wr, int a, logic [7:0] d);
    if (m_disabled()) begin
      m_cnt = 0;
      m_phase = 1;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
    end
    if (m_pend) begin
      for (int k = 0; k < 6; k++) m_act[k] = m_sh[k];
      m_pend = 0;
    end
    if (wr) m_write(a, d);
    if (m_disabled()) begin
      m_cnt = 0;
      m_phase = 1;
    end
  endfunction

  function automatic void m_fall();
    if (m_disabled()) begin
      m_cnt = 0;
      m_phase = 1;
    end else if (m_cnt >= int'(m_act[5])) begin
      m_phase = !m_phase;
      m_cnt = 0;
    end
  endfunction

  function automatic bit m_hit(bit de, int col, int row, int line);
    return de && m_act[4][0] && m_phase && (col == int'(m_act[0])) &&
           (row == int'(m_act[1])) && (line >= int'(m_act[2][3:0])) &&
           (line <= int'(m_act[3][3:0]));
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_h = 1'b1;
    step();
    step();
    i_rst_h = 1'b0;
    m_reset();
  endtask

  task automatic write_reg(int a, logic [7:0] d);
    i_wr_h = 1'b1;
    i_addr = a[2:0];
    i_data = d;
    step();
    i_wr_h = 1'b0;
    m_write(a, d);
  endtask

  task automatic vs_pulse();
    i_de_h = 1'b0;
    i_vs_h = 1'b1;
    step();
    m_rise(0, 0, 8'd0);
    step();
    i_vs_h = 1'b0;
    step();
    m_fall();
  endtask

  task automatic drive_pixel(bit de, int col, int row, int line);
    i_de_h = de;
    i_col = col[COL_W-1:0];
    i_row = row[ROW_W-1:0];
    i_line = line[LINE_W-1:0];
    exp_q.push_back({7'd0, m_hit(de, col, row, line)});
    step();
    i_de_h = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    int px[6][4] = '{'{1, 0, 0, 14}, '{1, 0, 0, 15}, '{1, 0, 0, 13},
                     '{1, 1, 0, 14}, '{1, 0, 1, 14}, '{0, 0, 0, 14}};
    do_reset();
    n_checks++;
    if (o_pend_h !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pend: got %b expected 0", o_pend_h); end
    n_checks++;
    if (o_phase_h !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_phase: got %b expected 1", o_phase_h); end
    n_checks++;
    if (o_cur_h !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cur: got %b expected 0", o_cur_h); end
    n_checks++;
    if (o_rdata !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 00", o_rdata); end
    for (int k = 0; k < 6; k++) begin
      drive_pixel(px[k][0] != 0, px[k][1], px[k][2], px[k][3]);
      e = exp_q.pop_front();
      n_checks++;
      if (o_cur_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL reset_hit%0d: got %b expected %b", k, o_cur_h, e[0]);
      end
    end
  endtask

  task automatic test_commit();
    logic [7:0] e;
    int px[4][2] = '{'{0, 0}, '{10, 3}, '{10, 3}, '{0, 0}};
    do_reset();
    write_reg(0, 8'd10);
    n_checks++;
    if (o_pend_h !== 1'b1) begin n_fail++; $display("[TB] FAIL commit_pend_set: got %b expected 1", o_pend_h); end
    write_reg(1, 8'd3);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        vs_pulse();
        n_checks++;
        if (o_pend_h !== m_pend) begin n_fail++; $display("[TB] FAIL commit_pend_clr: got %b expected %b", o_pend_h, m_pend); end
      end
      drive_pixel(1, px[k][0], px[k][1], 14);
      e = exp_q.pop_front();
      n_checks++;
      if (o_cur_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL commit_hit%0d: got %b expected %b", k, o_cur_h, e[0]);
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] e;
    do_reset();
    write_reg(5, 8'd2);
    vs_pulse();
    for (int k = 0; k < 8; k++) begin
      vs_pulse();
      exp_q.push_back({7'd0, m_phase});
      e = exp_q.pop_front();
      n_checks++;
      if (o_phase_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL blink_phase%0d: got %b expected %b", k, o_phase_h, e[0]);
      end
      drive_pixel(1, 0, 0, 14);
      e = exp_q.pop_front();
      n_checks++;
      if (o_cur_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL blink_hit%0d: got %b expected %b", k, o_cur_h, e[0]);
      end
    end
  endtask

  task automatic test_rate_drop();
    logic [7:0] e;
    do_reset();
    for (int k = 0; k < 5; k++) vs_pulse();
    write_reg(5, 8'd2);
    vs_pulse();
    exp_q.push_back({7'd0, m_phase});
    e = exp_q.pop_front();
    n_checks++;
    if (o_phase_h !== e[0]) begin
      n_fail++;
      $display("[TB] FAIL rate_drop_phase: got %b expected %b", o_phase_h, e[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int lines[4] = '{5, 14, 5, 4};
    do_reset();
    write_reg(3, 8'd15);
    i_vs_h = 1'b1;
    i_wr_h = 1'b1;
    i_addr = 3'd2;
    i_data = 8'd5;
    step();
    i_wr_h = 1'b0;
    m_rise(1, 2, 8'd5);
    step();
    i_vs_h = 1'b0;
    step();
    m_fall();
    n_checks++;
    if (o_pend_h !== m_pend) begin n_fail++; $display("[TB] FAIL b2b_pend: got %b expected %b", o_pend_h, m_pend); end
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        vs_pulse();
        n_checks++;
        if (o_pend_h !== m_pend) begin n_fail++; $display("[TB] FAIL b2b_pend_clr: got %b expected %b", o_pend_h, m_pend); end
      end
      drive_pixel(1, 0, 0, lines[k]);
      e = exp_q.pop_front();
      n_checks++;
      if (o_cur_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL b2b_hit%0d: got %b expected %b", k, o_cur_h, e[0]);
      end
    end
  endtask

  task automatic test_shape();
    logic [7:0] e;
    do_reset();
    write_reg(2, 8'd9);
    write_reg(3, 8'd4);
    vs_pulse();
    for (int l = 0; l < 16; l++) begin
      drive_pixel(1, 0, 0, l);
      e = exp_q.pop_front();
      n_checks++;
      if (o_cur_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL shape_inv_line%0d: got %b expected %b", l, o_cur_h, e[0]);
      end
    end
    write_reg(2, 8'd7);
    write_reg(3, 8'd7);
    vs_pulse();
    for (int l = 0; l < 16; l++) begin
      drive_pixel(1, 0, 0, l);
      e = exp_q.pop_front();
      n_checks++;
      if (o_cur_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL shape_single_line%0d: got %b expected %b", l, o_cur_h, e[0]);
      end
    end
  endtask

  task automatic test_blink_off();
    logic [7:0] e;
    do_reset();
    write_reg(5, 8'd1);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) write_reg(4, 8'h01);
      vs_pulse();
      exp_q.push_back({7'd0, m_phase});
      e = exp_q.pop_front();
      n_checks++;
      if (o_phase_h !== e[0]) begin
        n_fail++;
        $display("[TB] FAIL blink_off_phase%0d: got %b expected %b", k, o_phase_h, e[0]);
      end
    end
    drive_pixel(1, 0, 0, 15);
    e = exp_q.pop_front();
    n_checks++;
    if (o_cur_h !== e[0]) begin n_fail++; $display("[TB] FAIL blink_off_hit: got %b expected %b", o_cur_h, e[0]); end
  endtask

  task automatic test_readback();
    logic [7:0] e;
    int addrs[6] = '{4, 7, 2, 5, 0, 6};
    do_reset();
    write_reg(0, 8'hff);
    for (int k = 0; k < 6; k++) begin
      i_rd_h = 1'b1;
      i_addr = addrs[k][2:0];
`ifdef VGA_CUR_RDBACK_EN
      exp_q.push_back(addrs[k] < 6 ? m_act[addrs[k]] : 8'd0);
`else
      exp_q.push_back(8'd0);
`endif
      step();
      i_rd_h = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (o_rdata !== e) begin
        n_fail++;
        $display("[TB] FAIL rdata_addr%0d: got %h expected %h", addrs[k], o_rdata, e);
      end
      if (k == 2) begin
        exp_q.push_back(e);
        i_addr = 3'd5;
        step();
        e = exp_q.pop_front();
        n_checks++;
        if (o_rdata !== e) begin n_fail++; $display("[TB] FAIL rdata_hold: got %h expected %h", o_rdata, e); end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_commit();
    test_blink();
    test_rate_drop();
    test_back_to_back();
    test_shape();
    test_blink_off();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
